// File: rtl/pif_pkg.sv
// Shared constants and sizing helpers for the prefetch stage.
package pif_pkg;

  localparam int INST_BYTES = 4;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index a power-of-two storage array.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // A FIFO entry is packed as {pc, inst}.
  function automatic int entry_w(input int xlen);
    return 2 * xlen;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry32_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO; flush wins over push, push+pop honoured at full.
module fetch_fifo
  import pif_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pif_prefetch.sv
// Instruction prefetch stage: credit-limited memory requests feeding a
// {pc, inst} FIFO towards decode, with redirect flush and stale-response drop.
module pif_prefetch
  import pif_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            resp_err
);

  localparam int OW = cnt_w(MAX_OUTSTANDING);
  localparam int CW = cnt_w(DEPTH);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;
  localparam int EW = entry_w(XLEN);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   head;
  logic [SW-1:0]   in_use;
  logic            req_fire;
  logic            resp_ok;
  logic            resp_drop;
  logic            push;
  logic            pop;

  // Every in-flight request holds a FIFO slot, so responses always have room.
  assign in_use        = SW'(outstanding) + SW'(fifo_count);
  assign mem_req_valid = rst && !jump_en && !fifo_full &&
                         (in_use < SW'(DEPTH)) &&
                         (outstanding < OW'(MAX_OUTSTANDING));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign resp_ok   = mem_resp_valid && (outstanding != '0);
  assign resp_drop = resp_ok && (drop_cnt != '0);
  assign push      = resp_ok && !resp_drop && !jump_en;
  assign pop       = out_valid && out_ready && !jump_en;

  assign out_valid = !fifo_empty;
  assign out_pc    = head[EW-1:XLEN];
  assign out_inst  = head[XLEN-1:0];

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_en),
    .din   ({resp_pc, mem_resp_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch/response PCs, in-flight and stale-response counters, error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      resp_err    <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(req_fire) - OW'(resp_ok);
      if (mem_resp_valid && (outstanding == '0)) resp_err <= 1'b1;
      if (jump_en) begin
        fetch_pc <= jump_addr;
        resp_pc  <= jump_addr;
        // Whatever is still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - OW'(resp_ok);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
        if (push)      resp_pc  <= resp_pc + XLEN'(INST_BYTES);
        if (resp_drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pif_prefetch.sv
// Randomized bench for pif_prefetch against a path-epoch reference model.
module tb_pif_prefetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            resp_err;

  pif_prefetch #(
    .XLEN            (XLEN),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .resp_err       (resp_err)
  );

  always #5 clk = ~clk;

  // Model: requests in flight tagged with the path epoch they were issued on;
  // a response from an older epoch is stale and never reaches the FIFO.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } infl_t;

  infl_t       infl[$];
  logic [31:0] fq[$];
  logic [31:0] m_fetch_pc;
  int          epoch;
  bit          m_err;
  int          cyc;
  int          lat_max;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    fq.delete();
    m_fetch_pc = RESET_PC;
    m_err      = 1'b0;
    epoch++;
  endtask

  task automatic zero_inputs();
    jump_en        = 1'b0;
    jump_addr      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    out_ready      = 1'b0;
  endtask

  // One clock cycle: drive, check against model, advance model for the next edge.
  task automatic step(input bit jmp, input logic [31:0] ja, input bit ordy,
                      input bit mrdy, input bit unsol);
    bit    rv;
    bit    exp_rv;
    bit    exp_ov;
    infl_t e;
    int    lat;
    @(negedge clk);
    if (infl.size() > 0) rv = (infl[0].due <= cyc);
    else                 rv = unsol;
    jump_en        = jmp;
    jump_addr      = ja;
    out_ready      = ordy;
    mem_req_ready  = mrdy;
    mem_resp_valid = rv;
    mem_resp_data  = (infl.size() > 0) ? inst_of(infl[0].addr) : $urandom;
    #1;
    exp_rv = !jmp && (infl.size() + fq.size() < DEPTH) && (infl.size() < MAXO);
    exp_ov = (fq.size() > 0);
    chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", mem_req_addr, m_fetch_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_pc, fq[0]);
      chk("out_inst", out_inst, inst_of(fq[0]));
    end
    chk("resp_err", 32'(resp_err), 32'(m_err));
    if (exp_ov && ordy && !jmp) void'(fq.pop_front());
    if (rv) begin
      if (infl.size() == 0) m_err = 1'b1;
      else begin
        e = infl.pop_front();
        if (e.epoch == epoch && !jmp) fq.push_back(e.addr);
      end
    end
    if (exp_rv && mrdy) begin
      lat = $urandom_range(1, lat_max);
      infl.push_back('{m_fetch_pc, epoch, cyc + lat});
      m_fetch_pc += 32'd4;
    end
    if (jmp) begin
      fq.delete();
      epoch++;
      m_fetch_pc = ja;
    end
    cyc++;
  endtask

  task automatic run_rand(input int n, input int p_ordy, input int p_jump,
                          input int p_mrdy, input int p_unsol);
    logic [31:0] ja;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       ja = 32'hFFFF_FFF8;
        1:       ja = 32'h0000_0100;
        default: ja = $urandom & 32'hFFFF_FFFC;
      endcase
      step(($urandom_range(0, 99) < p_jump), ja, ($urandom_range(0, 99) < p_ordy),
           ($urandom_range(0, 99) < p_mrdy), ($urandom_range(0, 99) < p_unsol));
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must drop immediately.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst = 1'b0;
    zero_inputs();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    epoch   = 0;
    lat_max = 1;
    rst     = 1'b0;
    zero_inputs();
    model_reset();
    #3;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_req_valid", 32'(mem_req_valid), 32'd0);
    chk("init_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;

    // Streaming with a 1-cycle memory.
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Decode stall fills the FIFO, then drains in order.
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Slow memory with redirect while requests are in flight.
    lat_max = 3;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Back-to-back redirects.
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Address wrap.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Reset mid-stream, then an unsolicited response.
    reset_pulse();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Randomized mix.
    reset_pulse();
    run_rand(1500, 70, 5, 80, 0);
    run_rand(1000, 30, 15, 60, 3);
    reset_pulse();
    run_rand(1000, 90, 2, 95, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pif_prefetch.md
Name: pif_prefetch

Overview:
- Next-generation instruction-fetch stage: parametrised PC width, depth and outstanding-request count.
- Decouples instruction memory from decode with a valid/ready request/response memory port and a DEPTH-entry prefetch FIFO of {pc, inst} pairs.
- Handles redirects (jump) by flushing the FIFO and discarding in-flight responses.
- Sits between the memory/ROM arbiter and the IF/ID boundary; drives decode with a valid/ready handshake.

Parameters:
- XLEN, 32: PC and instruction width.
- DEPTH, 4: prefetch FIFO entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2: maximum memory requests in flight; 1 to DEPTH.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- jump_en  in  1  redirect request from a later stage.
- jump_addr  in  XLEN  redirect target; word aligned.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  fetch address.
- mem_resp_valid  in  1  response valid; always accepted, in order.
- mem_resp_data  in  XLEN  fetched instruction.
- out_valid  out  1  FIFO head valid to decode.
- out_ready  in  1  decode accepts; driven low by decode during stall.
- out_inst  out  XLEN  head instruction.
- out_pc  out  XLEN  head PC.
- resp_err  out  1  sticky: response seen with zero outstanding.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; resp_err=0.
  - out_valid=0 and mem_req_valid=0 while rst is low.
- Request issue: mem_req_valid = !jump_en && (outstanding + fifo_count < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - This credit rule reserves FIFO space, so a response is never dropped for lack of room.
  - mem_req_addr = fetch_pc.
  - On mem_req_valid && mem_req_ready: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding++.
- Response: each mem_resp_valid decrements outstanding.
  - If drop_cnt > 0: data discarded, drop_cnt--.
  - Otherwise: {pc, inst} pushed, with pc taken from an internal resp_pc register that advances by 4 per accepted response.
  - Response in the same cycle as a request: outstanding is unchanged net.
- Response with outstanding==0: ignored, resp_err set; cleared only by reset.
- Output: out_valid/out_inst/out_pc come from the registered FIFO head.
  - Pop on out_valid && out_ready && !jump_en.
  - Push and pop in the same cycle are both honoured, including at full and empty.
  - A response written at edge T is visible on out_valid after edge T; total latency from response to out_valid is 1 cycle.
- Redirect (jump_en high in cycle T), takes effect at edge T:
  - FIFO emptied; fetch_pc=jump_addr; resp_pc=jump_addr.
  - drop_cnt = outstanding, minus 1 if mem_resp_valid in T. A response in cycle T is itself discarded.
  - No request issued in cycle T. An out handshake in cycle T is void.
  - Minimum latency: request at T+1, earliest response T+2, out_valid T+3.
- Back-to-back jumps: each recomputes drop_cnt from the live outstanding count; the last target wins.
- A request issued while drop_cnt>0 belongs to the new path; in-order responses guarantee the drop count drains first.
- Stall: decode holds out_ready low. The FIFO fills to DEPTH, then requests stop. PC and head stay stable; no entry is lost or duplicated.
- Counter widths: outstanding and drop_cnt are $clog2(MAX_OUTSTANDING+1) bits; fifo_count is $clog2(DEPTH+1) bits.

Decomposition:
- Package pif_pkg holds:
  - INST_BYTES=4.
  - The parametrised fetch_entry_t {pc, inst} (typedef or width localparams).
  - Helper functions for counter widths.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, full, empty and count outputs.
  - Flush has priority over push.
  - Instantiated once for the entry storage.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle memory, out_ready=1 -> requests at 0x0,0x4,0x8…; out_pc stream 0x0,0x4,0x8 with no gaps after fill; resp_err=0.
- out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 entries buffered (pc 0x0–0xC), mem_req_valid low. Release -> 0x0,0x4,0x8,0xC then 0x10; no loss or duplicates.
- 3-cycle memory latency, 2 requests in flight, jump_en with jump_addr=0x100 -> both stale responses dropped. First out_pc=0x100; out_valid no earlier than T+3.
- jump_en in two consecutive cycles (0x200 then 0x300) with a response arriving in the second cycle -> only the 0x300 stream emerges; drop_cnt returns to 0.
- Unsolicited mem_resp_valid right after reset -> resp_err=1 sticky, FIFO unchanged. Async rst pulse mid-stream -> all outputs return to reset values immediately; fetch restarts at RESET_PC.
- fetch_pc near 2^XLEN (jump_addr=0xFFFF_FFFC) -> next request wraps to 0x0000_0000; the out_pc sequence matches.
